// File: rtl/brush_painter.sv
// brush_painter: turns paint-stamp and canvas-clear commands into a stream of
// single-pixel writes (brush/newColor/wx/wy), one pixel per clock.
// A paint stamp is a (2R+1)x(2R+1) square centred on the cursor, clipped to
// the canvas; a clear sweeps every pixel in raster order.
// Optional build macro BRUSH_ROUND_EN: trims the stamp to a round shape
// (positions with dx^2+dy^2 > R^2+R are not written; cycle count unchanged).
module brush_painter #(
   parameter int unsigned WIDTH      = 256,
   parameter int unsigned HEIGHT     = 128,
   parameter int unsigned MAX_RADIUS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmdValid,
   output logic       cmdReady,
   input  logic       cmdClear,
   input  logic [7:0] cx,
   input  logic [7:0] cy,
   input  logic [1:0] radius,
   input  logic [2:0] color,
   output logic       brush,
   output logic [2:0] newColor,
   output logic [7:0] wx,
   output logic [7:0] wy,
   output logic       done
);

   localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   // radius port is 2 bits wide, so the effective clamp never exceeds 3
   localparam int unsigned MAX_R_CLAMP = (MAX_RADIUS > 3) ? 3 : MAX_RADIUS;
   localparam logic [1:0]  MAX_R       = 2'(MAX_R_CLAMP);
   localparam logic signed [9:0] W_S   = 10'(WIDTH);
   localparam logic signed [9:0] H_S   = 10'(HEIGHT);
   localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAINT = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t state_q, state_d;

   // captured command
   logic [7:0] cx_q, cx_d;
   logic [7:0] cy_q, cy_d;
   logic [2:0] col_q, col_d;
   logic [1:0] reff_q, reff_d;

   // stamp offsets of the pixel currently on the outputs
   logic signed [9:0] dx_q, dx_d;
   logic signed [9:0] dy_q, dy_d;

   // raster position of the pixel currently on the outputs during a clear
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   // registered outputs
   logic       brush_q, brush_d;
   logic [7:0] wx_q, wx_d;
   logic [7:0] wy_q, wy_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;

   // combinational helpers
   logic [1:0]        reff_in;
   logic signed [9:0] reff_s_q;
   logic signed [9:0] reff_s_d;
   logic signed [9:0] px;
   logic signed [9:0] py;
   logic              in_canvas;
   logic              round_ok;
`ifdef BRUSH_ROUND_EN
   logic signed [9:0] dist_sq;
   logic signed [9:0] r_lim;
`endif

   // State, capture and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cx_q    <= 8'd0;
         cy_q    <= 8'd0;
         col_q   <= 3'd0;
         reff_q  <= 2'd0;
         dx_q    <= 10'sd0;
         dy_q    <= 10'sd0;
         x_q     <= '0;
         y_q     <= '0;
         brush_q <= 1'b0;
         wx_q    <= 8'd0;
         wy_q    <= 8'd0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         col_q   <= col_d;
         reff_q  <= reff_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         x_q     <= x_d;
         y_q     <= y_d;
         brush_q <= brush_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   // Next state, position advance, and the outputs for the next pixel cycle
   always_comb begin
      state_d   = state_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      col_d     = col_q;
      reff_d    = reff_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      x_d       = x_q;
      y_d       = y_q;
      brush_d   = 1'b0;
      wx_d      = wx_q;
      wy_d      = wy_q;
      done_d    = 1'b0;
      ready_d   = 1'b0;
      px        = 10'sd0;
      py        = 10'sd0;
      in_canvas = 1'b0;
      round_ok  = 1'b1;
`ifdef BRUSH_ROUND_EN
      dist_sq   = 10'sd0;
      r_lim     = 10'sd0;
`endif

      reff_in  = (radius > MAX_R) ? MAX_R : radius;
      reff_s_q = $signed({8'd0, reff_q});

      // advance through the operation
      case (state_q)
         IDLE: begin
            if (cmdValid) begin
               cx_d   = cx;
               cy_d   = cy;
               col_d  = color;
               reff_d = reff_in;
               if (cmdClear) begin
                  state_d = CLEAR;
                  x_d     = '0;
                  y_d     = '0;
               end else begin
                  state_d = PAINT;
                  dx_d    = -$signed({8'd0, reff_in});
                  dy_d    = -$signed({8'd0, reff_in});
               end
            end
         end
         PAINT: begin
            if (dx_q == reff_s_q && dy_q == reff_s_q) begin
               state_d = IDLE;
            end else if (dx_q == reff_s_q) begin
               dx_d = -reff_s_q;
               dy_d = dy_q + 10'sd1;
            end else begin
               dx_d = dx_q + 10'sd1;
            end
         end
         CLEAR: begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
               state_d = IDLE;
            end else if (x_q == X_LAST) begin
               x_d = '0;
               y_d = y_q + 1'b1;
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      reff_s_d = $signed({8'd0, reff_d});

      // outputs describe the pixel at the next position
      case (state_d)
         PAINT: begin
            px        = $signed({2'b00, cx_d}) + dx_d;
            py        = $signed({2'b00, cy_d}) + dy_d;
            in_canvas = (px >= 10'sd0) && (px < W_S) &&
                        (py >= 10'sd0) && (py < H_S);
`ifdef BRUSH_ROUND_EN
            dist_sq   = dx_d * dx_d + dy_d * dy_d;
            r_lim     = reff_s_d * reff_s_d + reff_s_d;
            round_ok  = (dist_sq <= r_lim);
`endif
            brush_d   = in_canvas && round_ok;
            wx_d      = px[7:0];
            wy_d      = py[7:0];
            done_d    = (dx_d == reff_s_d) && (dy_d == reff_s_d);
         end
         CLEAR: begin
            brush_d = 1'b1;
            wx_d    = 8'(x_d);
            wy_d    = 8'(y_d);
            done_d  = (x_d == X_LAST) && (y_d == Y_LAST);
         end
         default: begin
            ready_d = 1'b1;
         end
      endcase
   end

   assign cmdReady = ready_q;
   assign brush    = brush_q;
   assign newColor = col_q;
   assign wx       = wx_q;
   assign wy       = wy_q;
   assign done     = done_q;

endmodule
